seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter LEN, default 8, giving the operand/result width in bits, two's-complement signed.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled on rising clk.
REQ-005 SHALL have port in1  input  LEN  signed dividend; captured when start is accepted.
REQ-006 SHALL have port in2  input  LEN  signed divisor; captured when start is accepted.
REQ-007 SHALL have port quotient  output  LEN  signed quotient, registered.
REQ-008 SHALL have port remainder  output  LEN  signed remainder, registered.
REQ-009 SHALL have port overflow  output  1  result saturated or divisor zero; valid with done.
REQ-010 SHALL have port busy  output  1  high while state is CALC.
REQ-011 SHALL have port done  output  1  one-cycle pulse when quotient/remainder/overflow update.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in CALC is ignored, with no effect on the operation in progress.
REQ-014 On accepted start with in2 != 0 and not (in1 = -2^(LEN-1) and in2 = -1): capture operand magnitudes and signs, clear the iteration counter, and go to CALC.
REQ-015 CALC SHALL run unsigned restoring shift-subtract, one quotient bit per cycle, for exactly LEN cycles, then go to DONE.
REQ-016 Normal-path latency SHALL be LEN+1 rising edges from the accepting edge to the edge that asserts done (9 for LEN=8).
REQ-017 Quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend; |remainder| < |divisor|; in1 = quotient*in2 + remainder.
REQ-018 Divide-by-zero (in2 = 0) SHALL bypass CALC and reach DONE one edge after acceptance, with quotient = 2^(LEN-1)-1 if in1 >= 0 or -2^(LEN-1) if in1 < 0, remainder = in1, overflow = 1.
REQ-019 Overflow case (in1 = -2^(LEN-1), in2 = -1) SHALL bypass CALC and reach DONE one edge after acceptance, with quotient = 2^(LEN-1)-1, remainder = 0, overflow = 1.
REQ-020 Cases other than REQ-018 and REQ-019 SHALL produce overflow = 0.
REQ-021 In DONE, done = 1 for exactly one cycle; the next state is IDLE, or it starts a new operation if start = 1 (back-to-back, per REQ-014/018/019).
REQ-022 quotient, remainder and overflow SHALL change only on the edge entering DONE, and SHALL hold until the next entry into DONE.
REQ-023 Operand changes on in1/in2 after acceptance SHALL NOT affect the result in progress.
REQ-024 Internal datapath SHALL be LEN+1 bits wide for the partial remainder so that -2^(LEN-1) dividend and divisor magnitudes are exact.
REQ-025 busy SHALL be 1 in CALC only and 0 in IDLE and DONE.

Reset
REQ-026 reset_n = 0 SHALL immediately force state IDLE, quotient = 0, remainder = 0, overflow = 0, busy = 0, done = 0, counter = 0, independent of clk.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse.
REQ-028 The first start after reset_n rises SHALL be accepted on the first rising clk that samples it high.

Verification
REQ-029 LEN=8, start with in1=100, in2=7 -> busy high 8 cycles; done on the 9th edge; quotient=14, remainder=2, overflow=0.
REQ-030 in1=-100, in2=7 -> quotient=-14, remainder=-2; in1=100, in2=-7 -> quotient=-14, remainder=2; latency 9 edges.
REQ-031 in1=5, in2=0 -> done on the 1st edge after acceptance, quotient=127, remainder=5, overflow=1; in1=-5, in2=0 -> quotient=-128, remainder=-5.
REQ-032 in1=-128, in2=-1 -> done after 1 edge, quotient=127, remainder=0, overflow=1; in1=-128, in2=1 -> quotient=-128, remainder=0, overflow=0 after 9 edges.
REQ-033 Assert start again 3 cycles into CALC with different operands -> ignored, and the first result is unchanged; start held high during DONE -> the second operation begins with no idle cycle.
REQ-034 Pulse reset_n low mid-CALC -> outputs are 0 at once and no done pulse follows; then a fresh start with in1=127, in2=127 -> quotient=1, remainder=0.

Source files
------------

// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
// Module      : seq_div
// Description : Multi-cycle signed divider (restoring shift-subtract, one
//               quotient bit per clock), with divide-by-zero and overflow bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div #(
    parameter int LEN = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic signed [LEN-1:0] in1,
    input  logic signed [LEN-1:0] in2,
    output logic signed [LEN-1:0] quotient,
    output logic signed [LEN-1:0] remainder,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(LEN + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [LEN-1:0] c_MIN  = {1'b1, {(LEN-1){1'b0}}};
    localparam logic [LEN-1:0] c_MAX  = {1'b0, {(LEN-1){1'b1}}};
    localparam logic [LEN-1:0] c_ONES = {LEN{1'b1}};
    localparam logic [CW-1:0]  c_LAST = CW'(LEN - 1);
    localparam logic [CW-1:0]  c_ONE  = CW'(1);

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [CW-1:0]  r_count;
    logic [LEN:0]   r_rem;
    logic [LEN-1:0] r_dvd;
    logic [LEN:0]   r_dvs;
    logic           r_neg_q;
    logic           r_neg_r;

    logic           w_accept;
    logic           w_div0;
    logic           w_ovf;
    logic [LEN-1:0] w_a_mag;
    logic [LEN-1:0] w_b_mag;
    logic [LEN:0]   w_shift;
    logic [LEN:0]   w_rem_nxt;
    logic [LEN-1:0] w_dvd_nxt;
    logic [LEN-1:0] w_rem_mag;

    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_div0   = (in2 == '0);
    assign w_ovf    = (in1 == c_MIN) && (in2 == c_ONES);

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(LEN-1).
    assign w_a_mag  = in1[LEN-1] ? LEN'(-in1) : in1;
    assign w_b_mag  = in2[LEN-1] ? LEN'(-in2) : in2;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign w_shift  = {r_rem[LEN-1:0], r_dvd[LEN-1]};
    always_comb begin
        w_rem_nxt = w_shift;
        w_dvd_nxt = {r_dvd[LEN-2:0], 1'b0};
        if (w_shift >= r_dvs) begin
            w_rem_nxt = w_shift - r_dvs;
            w_dvd_nxt = {r_dvd[LEN-2:0], 1'b1};
        end
    end
    assign w_rem_mag = w_rem_nxt[LEN-1:0];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = c_IDLE;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_state_nxt = (w_div0 || w_ovf) ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                w_state_nxt = (r_count == c_LAST) ? c_DONE : c_CALC;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_CALC:  busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
        end else if (w_accept) begin
            if (w_div0) begin
                quotient  <= in1[LEN-1] ? c_MIN : c_MAX;
                remainder <= in1;
                overflow  <= 1'b1;
            end else if (w_ovf) begin
                quotient  <= c_MAX;
                remainder <= '0;
                overflow  <= 1'b1;
            end else begin
                r_count <= '0;
                r_rem   <= '0;
                r_dvd   <= w_a_mag;
                r_dvs   <= {1'b0, w_b_mag};
                r_neg_q <= in1[LEN-1] ^ in2[LEN-1];
                r_neg_r <= in1[LEN-1];
            end
        end else if (r_state == c_CALC) begin
            r_rem   <= w_rem_nxt;
            r_dvd   <= w_dvd_nxt;
            r_count <= r_count + c_ONE;
            if (r_count == c_LAST) begin
                quotient  <= r_neg_q ? LEN'(-w_dvd_nxt) : w_dvd_nxt;
                remainder <= r_neg_r ? LEN'(-w_rem_mag) : w_rem_mag;
                overflow  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_div
// Description : Directed self-checking bench for seq_div (LEN = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic signed [7:0] in1;
    logic signed [7:0] in2;
    logic signed [7:0] quotient;
    logic signed [7:0] remainder;
    logic              overflow;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    seq_div #(.LEN(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in1       (in1),
        .in2       (in2),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept edge counts as edge 1; returns edges until done and busy samples.
    task automatic run(input string tag, input logic signed [7:0] a,
                       input logic signed [7:0] b, input int eq, input int er,
                       input int eo, input int elat);
        int n;
        int nb;
        @(negedge clk);
        start = 1'b1; in1 = a; in2 = b;
        @(posedge clk); #1;
        start = 1'b0; in1 = 8'sh5A; in2 = -8'sd3;
        n = 1; nb = busy;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++; nb += busy;
        end
        chk({tag, "_lat"},  n, elat);
        chk({tag, "_busy"}, nb, elat - 1);
        chk({tag, "_q"},    quotient, eq);
        chk({tag, "_r"},    remainder, er);
        chk({tag, "_ovf"},  overflow, eo);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hold"}, quotient, eq);
    endtask

    initial begin
        int n;
        int seen;
        reset_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
        #1;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run("p100d7",   8'sd100,  8'sd7,    14,   2, 0, 9);
        run("n100d7",  -8'sd100,  8'sd7,   -14,  -2, 0, 9);
        run("p100dn7",  8'sd100, -8'sd7,   -14,   2, 0, 9);
        run("n100dn7", -8'sd100, -8'sd7,    14,  -2, 0, 9);
        run("div0p",    8'sd5,    8'sd0,   127,   5, 1, 1);
        run("div0n",   -8'sd5,    8'sd0,  -128,  -5, 1, 1);
        run("ovf",     -8'sd128, -8'sd1,   127,   0, 1, 1);
        run("min_d1",  -8'sd128,  8'sd1,  -128,   0, 0, 9);
        run("min_d3",  -8'sd128,  8'sd3,   -42,  -2, 0, 9);
        run("small",    8'sd7,    8'sd100,   0,   7, 0, 9);

        // Start asserted during CALC is ignored
        @(negedge clk);
        start = 1'b1; in1 = 8'sd100; in2 = 8'sd7;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        repeat (3) @(posedge clk);
        #1; n += 3;
        start = 1'b1; in1 = 8'sd50; in2 = 8'sd5;
        @(posedge clk); #1;
        n++; start = 1'b0;
        chk("ign_busy", busy, 1);
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign_lat", n, 9);
        chk("ign_q", quotient, 14);
        chk("ign_r", remainder, 2);
        repeat (2) @(posedge clk);

        // Start held through DONE chains the next operation with no idle cycle
        @(negedge clk);
        start = 1'b1; in1 = 8'sd100; in2 = 8'sd7;
        @(posedge clk); #1;
        in1 = -8'sd100; in2 = 8'sd7;
        n = 1;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_lat1", n, 9);
        chk("b2b_q1", quotient, 14);
        chk("b2b_r1", remainder, 2);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done", done, 0);
        n = 1;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_lat2", n, 9);
        chk("b2b_q2", quotient, -14);
        chk("b2b_r2", remainder, -2);
        repeat (2) @(posedge clk);

        // Reset mid-CALC aborts with no done pulse
        @(negedge clk);
        start = 1'b1; in1 = 8'sd100; in2 = 8'sd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_ovf", overflow, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            seen += done;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            seen += done;
        end
        chk("abort_nodone", seen, 0);

        run("p127d127", 8'sd127, 8'sd127, 1, 0, 0, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
